// File: rtl/inferencia_seq_ctrl.sv
// Rule-sequencing controller for the interval type-2 inference datapath.
// Optional per-rule enable mask when RULE_MASK_EN is defined.
module inferencia_seq_ctrl #(
  parameter int unsigned N_MF_A = 3,
  parameter int unsigned N_MF_B = 3,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned DRAIN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       hold,
`ifdef RULE_MASK_EN
  input  logic [N_MF_A*N_MF_B-1:0]   rule_mask,
`endif
  output logic [3:0]                 Sequencia_regras,
  output logic                       EN_Cod_Mem,
  output logic                       captura,
  output logic [3:0]                 regra_idx,
  output logic                       busy,
  output logic                       done
);

  localparam logic [1:0] A_LAST    = 2'(N_MF_A - 1);
  localparam logic [1:0] B_LAST    = 2'(N_MF_B - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [3:0] DRAIN_LD  = 4'(DRAIN - 1);
  localparam logic [3:0] NA4       = 4'(N_MF_A);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_WAIT, S_CAPTURE, S_SKIP, S_DRAIN, S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_a_q, idx_a_d;
  logic [1:0] idx_b_q, idx_b_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] nxt_a, nxt_b;
  logic       last_rule;
  logic       first_en, nxt_en;

  always_comb begin
    last_rule = (idx_a_q == A_LAST) && (idx_b_q == B_LAST);
    if (idx_a_q == A_LAST) begin
      nxt_a = '0;
      nxt_b = idx_b_q + 2'd1;
    end else begin
      nxt_a = idx_a_q + 2'd1;
      nxt_b = idx_b_q;
    end
  end

`ifdef RULE_MASK_EN
  logic [N_MF_A*N_MF_B-1:0] mask_q, mask_d, mask_sh;

  always_comb begin
    mask_d = mask_q;
    if (state_q == S_IDLE && start && !hold) mask_d = rule_mask;
    // Shift instead of indexing keeps the select width independent of the rule count.
    mask_sh  = mask_q >> (4'(nxt_b) * NA4 + 4'(nxt_a));
    nxt_en   = mask_sh[0];
    first_en = rule_mask[0];
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`else
  assign nxt_en   = 1'b1;
  assign first_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      case (state_q)
        S_IDLE: if (start) state_d = first_en ? S_APPLY : S_SKIP;
        S_APPLY: begin
          cnt_d   = SETTLE_LD;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_CAPTURE;
          else             cnt_d   = cnt_q - 4'd1;
        end
        S_CAPTURE, S_SKIP: begin
          if (!last_rule) begin
            idx_a_d = nxt_a;
            idx_b_d = nxt_b;
            state_d = nxt_en ? S_APPLY : S_SKIP;
          end else if (DRAIN == 0) begin
            idx_a_d = '0;
            idx_b_d = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = DRAIN_LD;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            idx_a_d = '0;
            idx_b_d = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_a_q <= '0;
      idx_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are masked by hold so a frozen state re-issues them exactly once on release.
  always_comb begin
    busy             = (state_q != S_IDLE);
    EN_Cod_Mem       = (state_q != S_IDLE) && (state_q != S_DONE);
    captura          = (state_q == S_CAPTURE) && !hold;
    done             = (state_q == S_DONE) && !hold;
    Sequencia_regras = EN_Cod_Mem ? {idx_b_q, idx_a_q} : '0;
    regra_idx        = 4'(idx_b_q) * NA4 + 4'(idx_a_q);
  end

endmodule

// File: tb/tb_inferencia_seq_ctrl.sv
// Bench for inferencia_seq_ctrl: default and a 2x2/SETTLE=1/DRAIN=0 instance
// checked every cycle against a timeline model; RULE_MASK_EN adds mask stimulus.
module tb_inferencia_seq_ctrl;

  logic clk = 1'b0;
  logic rst, start, hold;
  logic [3:0] seq0, idx0, seq1, idx1;
  logic en0, cap0, busy0, done0, en1, cap1, busy1, done1;
`ifdef RULE_MASK_EN
  logic [8:0] mask0 = '1;
  logic [3:0] mask1 = '1;
`endif

  always #5 clk = ~clk;

  inferencia_seq_ctrl u0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
`ifdef RULE_MASK_EN
    .rule_mask(mask0),
`endif
    .Sequencia_regras(seq0), .EN_Cod_Mem(en0), .captura(cap0),
    .regra_idx(idx0), .busy(busy0), .done(done0)
  );

  inferencia_seq_ctrl #(.N_MF_A(2), .N_MF_B(2), .SETTLE(1), .DRAIN(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
`ifdef RULE_MASK_EN
    .rule_mask(mask1),
`endif
    .Sequencia_regras(seq1), .EN_Cod_Mem(en1), .captura(cap1),
    .regra_idx(idx1), .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [3:0] seq;
    logic       en;
    logic       cap;
    logic [3:0] idx;
    logic       busy;
    logic       done;
    logic       valid;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit act[2];
  int pos[2];
  logic [15:0] mmask[2];
  int t0[2], cap_seen[2], done_seen[2], done_lat[2];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs at position p of a sweep: each rule is SETTLE+2 cycles
  // ending in a capture (or one cycle if masked off), then DRAIN cycles, then done.
  function automatic exp_t exp_at(input int na, input int nb, input int st, input int dr,
                                  input logic [15:0] mask, input int p);
    exp_t e;
    int t;
    e = '0;
    t = p;
    for (int k = 0; k < na * nb; k++) begin
      logic [15:0] m;
      int len;
      m   = mask >> k;
      len = m[0] ? st + 2 : 1;
      if (t < len) begin
        e.seq   = 4'(((k / na) << 2) | (k % na));
        e.en    = 1'b1;
        e.cap   = m[0] && (t == len - 1);
        e.idx   = 4'(k);
        e.busy  = 1'b1;
        e.valid = 1'b1;
        return e;
      end
      t -= len;
    end
    if (t < dr) begin
      e.seq   = 4'(((nb - 1) << 2) | (na - 1));
      e.en    = 1'b1;
      e.idx   = 4'(na * nb - 1);
      e.busy  = 1'b1;
      e.valid = 1'b1;
      return e;
    end
    t -= dr;
    if (t == 0) begin
      e.done  = 1'b1;
      e.busy  = 1'b1;
      e.valid = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t model(input int i);
    if (!act[i]) return '0;
    if (i == 0) return exp_at(3, 3, 2, 1, mmask[0], pos[0]);
    return exp_at(2, 2, 1, 0, mmask[1], pos[1]);
  endfunction

  task automatic check_outs(input string who, input exp_t e, input logic h,
                            input logic [3:0] seq, input logic en, input logic cap,
                            input logic [3:0] idx, input logic busy, input logic dn);
    chk({who, ".seq"},  16'(seq),  16'(e.seq));
    chk({who, ".en"},   16'(en),   16'(e.en));
    chk({who, ".cap"},  16'(cap),  16'(e.cap & !h));
    chk({who, ".idx"},  16'(idx),  16'(e.idx));
    chk({who, ".busy"}, 16'(busy), 16'(e.busy));
    chk({who, ".done"}, 16'(dn),   16'(e.done & !h));
  endtask

  task automatic step(input logic s, input logic h, input logic r);
    start = s;
    hold  = h;
    rst   = r;
    @(negedge clk);
    check_outs("u0", model(0), h, seq0, en0, cap0, idx0, busy0, done0);
    check_outs("u1", model(1), h, seq1, en1, cap1, idx1, busy1, done1);
    if (cap0 === 1'b1) cap_seen[0]++;
    if (cap1 === 1'b1) cap_seen[1]++;
    if (done0 === 1'b1) begin done_seen[0]++; done_lat[0] = cyc - t0[0] + 1; end
    if (done1 === 1'b1) begin done_seen[1]++; done_lat[1] = cyc - t0[1] + 1; end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        act[i] = 1'b0;
      end else if (!h) begin
        if (act[i]) begin
          pos[i]++;
          if (!model(i).valid) act[i] = 1'b0;
        end else if (s) begin
          act[i]       = 1'b1;
          pos[i]       = 0;
          t0[i]        = cyc;
          cap_seen[i]  = 0;
          done_seen[i] = 0;
          done_lat[i]  = -1;
`ifdef RULE_MASK_EN
          mmask[i] = (i == 0) ? 16'(mask0) : 16'(mask1);
`else
          mmask[i] = '1;
`endif
        end
      end
    end
    #1;
  endtask

  task automatic sweep_chk(input string tag, input int lat0, input int caps0,
                           input int lat1, input int caps1);
    chk({tag, ".lat0"},  16'(done_lat[0]),  16'(lat0));
    chk({tag, ".caps0"}, 16'(cap_seen[0]),  16'(caps0));
    chk({tag, ".dn0"},   16'(done_seen[0]), 16'd1);
    chk({tag, ".lat1"},  16'(done_lat[1]),  16'(lat1));
    chk({tag, ".caps1"}, 16'(cap_seen[1]),  16'(caps1));
    chk({tag, ".dn1"},   16'(done_seen[1]), 16'd1);
  endtask

  initial begin
    act = '{default: 1'b0};
    pos = '{default: 0};
    start = 1'b0;
    hold  = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) step(0, 0, 1);
    repeat (2) step(0, 0, 0);

    // Plain sweep
    step(1, 0, 0);
    repeat (44) step(0, 0, 0);
    sweep_chk("plain", 38, 9, 13, 4);

    // Second start mid-sweep is ignored
    step(1, 0, 0);
    for (int j = 1; j <= 44; j++) step(j == 10, 0, 0);
    sweep_chk("restart", 38, 9, 13, 4);

    // Hold during rule 1 wait shifts everything by 4
    step(1, 0, 0);
    for (int j = 1; j <= 48; j++) step(0, j >= 6 && j <= 9, 0);
    sweep_chk("hold", 42, 9, 17, 4);

    // Reset mid-sweep aborts without done, then a fresh full sweep
    step(1, 0, 0);
    for (int j = 1; j <= 24; j++) step(0, 0, j == 20);
    chk("abort.dn0", 16'(done_seen[0]), 16'd0);
    step(1, 0, 0);
    repeat (44) step(0, 0, 0);
    sweep_chk("after_rst", 38, 9, 13, 4);

`ifdef RULE_MASK_EN
    mask0 = 9'b100000001;
    mask1 = 4'b0000;
    step(1, 0, 0);
    repeat (24) step(0, 0, 0);
    chk("mask.lat0",  16'(done_lat[0]),  16'd17);
    chk("mask.caps0", 16'(cap_seen[0]),  16'd2);
    chk("mask.lat1",  16'(done_lat[1]),  16'd5);
    chk("mask.caps1", 16'(cap_seen[1]),  16'd0);
`endif

    repeat (2500) begin
`ifdef RULE_MASK_EN
      mask0 = 9'($urandom);
      mask1 = 4'($urandom);
`endif
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
